// File: rtl/csum_pkg.sv
// Shared widths and FSM state type for the checksum stream arbiter.
// Latency: none (definitions only).
// Backpressure: not applicable.
package csum_pkg;

    localparam int CSUM_DATA_W = 64;
    localparam int CSUM_KEEP_W = 8;
    localparam int CSUM_W      = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } csum_arb_state_t;

endpackage

// File: rtl/csum_stream_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NUM_SRC.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is registered.
module rr_pick #(
    parameter  int NUM_SRC = 2,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   grant_idx,
    output logic               any
);

    localparam logic [SRC_W:0] NUM_L = (SRC_W+1)'(NUM_SRC);

    logic [NUM_SRC-1:0] rot;
    logic [SRC_W-1:0]   off;
    logic [SRC_W:0]     sum;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rot[i] = req[(i + int'(ptr)) % NUM_SRC];
        end
        off = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SRC_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NUM_L) begin
            sum = sum - NUM_L;
        end
        grant_idx = sum[SRC_W-1:0];
        any       = |req;
    end

endmodule

// File: rtl/csum_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one checksum engine; tags each result with its source.
// Latency: 1-cycle arbitration, 0-cycle beat forwarding, result 2 cycles after the last handshake.
// Backpressure: only the granted source sees m_axi_ready; results are unbackpressured pulses.
module csum_stream_arbiter
    import csum_pkg::*;
#(
    parameter  int NUM_SRC = 2,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                           clk,
    input  logic                           aresetn,
    input  logic [NUM_SRC-1:0]             src_enable,
    input  logic [NUM_SRC-1:0]             s_axi_valid,
    input  logic [NUM_SRC*CSUM_DATA_W-1:0] s_axi_data,
    input  logic [NUM_SRC*CSUM_KEEP_W-1:0] s_axi_tkeep,
    input  logic [NUM_SRC-1:0]             s_axi_last,
    output logic [NUM_SRC-1:0]             s_axi_ready,
    output logic                           m_axi_valid,
    output logic [CSUM_DATA_W-1:0]         m_axi_data,
    output logic [CSUM_KEEP_W-1:0]         m_axi_tkeep,
    output logic                           m_axi_last,
    input  logic                           m_axi_ready,
    input  logic                           checksum_valid,
    input  logic [CSUM_W-1:0]              checksum_data,
    output logic                           res_valid,
    output logic [CSUM_W-1:0]              res_checksum,
    output logic [SRC_W-1:0]               res_src,
    output logic                           err_orphan,
    output logic                           busy
);

    csum_arb_state_t  state_q, state_d;
    logic [SRC_W-1:0] grant_q, grant_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0] pend_src_q;
    logic             pend_vld_q;
    logic             res_valid_q;
    logic [CSUM_W-1:0] res_checksum_q;
    logic [SRC_W-1:0] res_src_q;
    logic             err_orphan_q;

    logic [NUM_SRC-1:0] req;
    logic [SRC_W-1:0]   pick_idx;
    logic               pick_any;
    logic               pkt_done;

    // Enable is only consulted here, so masking a source mid-packet cannot cut it short.
    assign req = s_axi_valid & src_enable;

    rr_pick #(.NUM_SRC(NUM_SRC)) u_rr_pick (
        .req       (req),
        .ptr       (rr_ptr_q),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // Next-state, grant lock and combinational beat mux from the registered grant.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        pkt_done    = 1'b0;
        s_axi_ready = '0;
        m_axi_valid = 1'b0;
        m_axi_data  = '0;
        m_axi_tkeep = '0;
        m_axi_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                m_axi_valid          = s_axi_valid[grant_q];
                m_axi_data           = s_axi_data[grant_q*CSUM_DATA_W +: CSUM_DATA_W];
                m_axi_tkeep          = s_axi_tkeep[grant_q*CSUM_KEEP_W +: CSUM_KEEP_W];
                m_axi_last           = s_axi_last[grant_q];
                s_axi_ready[grant_q] = m_axi_ready;
                if (m_axi_valid && m_axi_ready && m_axi_last) begin
                    pkt_done = 1'b1;
                    rr_ptr_d = (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
                    // Returning to IDLE forces one beat-free cycle for the engine.
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Pending-source tag and result register; a new packet end outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            pend_vld_q     <= 1'b0;
            pend_src_q     <= '0;
            res_valid_q    <= 1'b0;
            res_checksum_q <= '0;
            res_src_q      <= '0;
            err_orphan_q   <= 1'b0;
        end else begin
            res_valid_q <= checksum_valid && pend_vld_q;
            if (checksum_valid && pend_vld_q) begin
                res_checksum_q <= checksum_data;
                res_src_q      <= pend_src_q;
            end
            if (checksum_valid && !pend_vld_q) begin
                err_orphan_q <= 1'b1;
            end
            if (pkt_done) begin
                pend_vld_q <= 1'b1;
                pend_src_q <= grant_q;
            end else if (checksum_valid) begin
                pend_vld_q <= 1'b0;
            end
        end
    end

    assign res_valid    = res_valid_q;
    assign res_checksum = res_checksum_q;
    assign res_src      = res_src_q;
    assign err_orphan   = err_orphan_q;
    assign busy         = (state_q == GRANT);

endmodule

// File: tb/tb_csum_stream_arbiter.sv
// Directed bench for csum_stream_arbiter with two sources and an inline engine model.
// Latency: checks sampled 2 time units after each rising edge.
// Backpressure: m_axi_ready driven directly by the directed steps.
module tb_csum_stream_arbiter;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [1:0]    src_enable;
    logic [1:0]    s_axi_valid;
    logic [127:0]  s_axi_data;
    logic [15:0]   s_axi_tkeep;
    logic [1:0]    s_axi_last;
    logic [1:0]    s_axi_ready;
    logic          m_axi_valid;
    logic [63:0]   m_axi_data;
    logic [7:0]    m_axi_tkeep;
    logic          m_axi_last;
    logic          m_axi_ready;
    logic          checksum_valid;
    logic [15:0]   checksum_data;
    logic          res_valid;
    logic [15:0]   res_checksum;
    logic          res_src;
    logic          err_orphan;
    logic          busy;

    int         total = 0;
    int         bad   = 0;
    int         bc[2];
    int         pk[2];
    int         plen[2];
    logic [1:0] src_on;
    logic [15:0] cs_seq;

    csum_stream_arbiter #(.NUM_SRC(2)) dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .src_enable     (src_enable),
        .s_axi_valid    (s_axi_valid),
        .s_axi_data     (s_axi_data),
        .s_axi_tkeep    (s_axi_tkeep),
        .s_axi_last     (s_axi_last),
        .s_axi_ready    (s_axi_ready),
        .m_axi_valid    (m_axi_valid),
        .m_axi_data     (m_axi_data),
        .m_axi_tkeep    (m_axi_tkeep),
        .m_axi_last     (m_axi_last),
        .m_axi_ready    (m_axi_ready),
        .checksum_valid (checksum_valid),
        .checksum_data  (checksum_data),
        .res_valid      (res_valid),
        .res_checksum   (res_checksum),
        .res_src        (res_src),
        .err_orphan     (err_orphan),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Beat payload encodes source, packet number and beat number.
    function automatic logic [63:0] dval(input int s, input int p, input int b);
        return 64'hA5A5_0000_0000_0000 | (64'(s) << 16) | (64'(p) << 8) | 64'(b);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            s_axi_data[64*i +: 64] = dval(i, pk[i], bc[i]);
            s_axi_tkeep[8*i +: 8]  = (i == 0) ? 8'hFF : 8'h0F;
            s_axi_last[i]          = (bc[i] == plen[i] - 1);
        end
        s_axi_valid = src_on;
    endtask

    // One clock: record handshakes, advance source beat counters, play the engine.
    task automatic step();
        logic [1:0] hs;
        logic       lh;
        #1;
        hs = s_axi_ready & s_axi_valid;
        lh = m_axi_valid & m_axi_ready & m_axi_last;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (hs[i]) begin
                if (bc[i] == plen[i] - 1) begin
                    bc[i] = 0;
                    pk[i]++;
                end else begin
                    bc[i]++;
                end
            end
        end
        checksum_valid = lh;
        checksum_data  = lh ? cs_seq : 16'h0;
        if (lh) cs_seq++;
        drive();
        #1;
    endtask

    initial begin
        bc = '{0, 0}; pk = '{0, 0}; plen = '{3, 3};
        src_on = 2'b00; cs_seq = 16'hBEEF;
        aresetn = 1'b0; src_enable = 2'b00; m_axi_ready = 1'b0;
        checksum_valid = 1'b0; checksum_data = 16'h0;
        drive();
        step(); step();
        chk("rst_s_ready", 64'(s_axi_ready), 64'(0));
        chk("rst_m_valid", 64'(m_axi_valid), 64'(0));
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_err_orphan", 64'(err_orphan), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));

        // Single source, 3 beats
        aresetn = 1'b1; src_enable = 2'b11; src_on = 2'b01; m_axi_ready = 1'b1;
        drive(); #1;
        chk("t1_idle_busy", 64'(busy), 64'(0));
        chk("t1_idle_m_valid", 64'(m_axi_valid), 64'(0));
        step();
        chk("t1_b0_m_valid", 64'(m_axi_valid), 64'(1));
        chk("t1_b0_data", m_axi_data, dval(0, 0, 0));
        chk("t1_b0_s_ready", 64'(s_axi_ready), 64'(2'b01));
        step();
        chk("t1_b1_data", m_axi_data, dval(0, 0, 1));
        chk("t1_b1_s_ready", 64'(s_axi_ready), 64'(2'b01));
        step();
        chk("t1_b2_data", m_axi_data, dval(0, 0, 2));
        chk("t1_b2_last", 64'(m_axi_last), 64'(1));
        chk("t1_b2_keep", 64'(m_axi_tkeep), 64'(8'hFF));
        src_on = 2'b00;
        step();
        chk("t1_gap_busy", 64'(busy), 64'(0));
        chk("t1_gap_res_valid", 64'(res_valid), 64'(0));
        step();
        chk("t1_res_valid", 64'(res_valid), 64'(1));
        chk("t1_res_cks", 64'(res_checksum), 64'(16'hBEEF));
        chk("t1_res_src", 64'(res_src), 64'(0));
        step();
        chk("t1_res_pulse", 64'(res_valid), 64'(0));

        // Round-robin from a fresh pointer, 2-beat packets
        aresetn = 1'b0; step(); aresetn = 1'b1;
        src_enable = 2'b11; src_on = 2'b11; plen = '{2, 2}; m_axi_ready = 1'b1;
        drive(); #1;
        chk("t2_idle_busy", 64'(busy), 64'(0));
        step();
        chk("t2_p0_s_ready", 64'(s_axi_ready), 64'(2'b01));
        chk("t2_p0_data", m_axi_data, dval(0, 1, 0));
        step();
        chk("t2_p0_last", 64'(m_axi_last), 64'(1));
        step();
        chk("t2_gap0_busy", 64'(busy), 64'(0));
        chk("t2_gap0_s_ready", 64'(s_axi_ready), 64'(0));
        step();
        chk("t2_p1_s_ready", 64'(s_axi_ready), 64'(2'b10));
        chk("t2_p1_data", m_axi_data, dval(1, 0, 0));
        chk("t2_p1_keep", 64'(m_axi_tkeep), 64'(8'h0F));
        chk("t2_r0_valid", 64'(res_valid), 64'(1));
        chk("t2_r0_src", 64'(res_src), 64'(0));
        chk("t2_r0_cks", 64'(res_checksum), 64'(16'hBEF0));
        step();
        chk("t2_r0_pulse", 64'(res_valid), 64'(0));
        step();
        chk("t2_gap1_busy", 64'(busy), 64'(0));
        step();
        chk("t2_p2_s_ready", 64'(s_axi_ready), 64'(2'b01));
        chk("t2_p2_data", m_axi_data, dval(0, 2, 0));
        chk("t2_r1_src", 64'(res_src), 64'(1));
        chk("t2_r1_cks", 64'(res_checksum), 64'(16'hBEF1));
        step();
        step();
        chk("t2_gap2_busy", 64'(busy), 64'(0));
        step();
        chk("t2_p3_s_ready", 64'(s_axi_ready), 64'(2'b10));
        chk("t2_p3_data", m_axi_data, dval(1, 1, 0));
        chk("t2_r2_src", 64'(res_src), 64'(0));
        step();
        src_on = 2'b00;
        step();
        step();
        chk("t2_r3_valid", 64'(res_valid), 64'(1));
        chk("t2_r3_src", 64'(res_src), 64'(1));
        chk("t2_r3_cks", 64'(res_checksum), 64'(16'hBEF3));
        chk("t2_end_busy", 64'(busy), 64'(0));

        // Mask: only src1 enabled, then disabled mid-packet
        src_enable = 2'b10; src_on = 2'b11; plen[1] = 3;
        drive(); #1;
        step();
        chk("t3_grant_s_ready", 64'(s_axi_ready), 64'(2'b10));
        chk("t3_b0_data", m_axi_data, dval(1, 2, 0));
        src_enable = 2'b00;
        step();
        chk("t3_b1_data", m_axi_data, dval(1, 2, 1));
        chk("t3_b1_s_ready", 64'(s_axi_ready), 64'(2'b10));
        step();
        chk("t3_b2_last", 64'(m_axi_last), 64'(1));
        step();
        chk("t3_gap_busy", 64'(busy), 64'(0));
        step();
        chk("t3_res_src", 64'(res_src), 64'(1));
        chk("t3_res_cks", 64'(res_checksum), 64'(16'hBEF4));
        chk("t3_masked_busy", 64'(busy), 64'(0));
        step();
        chk("t3_masked_busy2", 64'(busy), 64'(0));
        chk("t3_masked_m_valid", 64'(m_axi_valid), 64'(0));
        src_on = 2'b00;

        // Backpressure on a 4-beat src0 packet
        src_enable = 2'b11; src_on = 2'b01; plen[0] = 4; m_axi_ready = 1'b1;
        drive(); #1;
        step();
        chk("t4_c1_data", m_axi_data, dval(0, 3, 0));
        chk("t4_c1_s_ready", 64'(s_axi_ready), 64'(2'b01));
        step(); m_axi_ready = 1'b0; #1;
        chk("t4_c2_s_ready", 64'(s_axi_ready), 64'(2'b00));
        chk("t4_c2_data", m_axi_data, dval(0, 3, 1));
        chk("t4_c2_busy", 64'(busy), 64'(1));
        step(); m_axi_ready = 1'b1; #1;
        chk("t4_c3_s_ready", 64'(s_axi_ready), 64'(2'b01));
        chk("t4_c3_data", m_axi_data, dval(0, 3, 1));
        step(); m_axi_ready = 1'b0; #1;
        chk("t4_c4_data", m_axi_data, dval(0, 3, 2));
        step(); m_axi_ready = 1'b1; #1;
        chk("t4_c5_data", m_axi_data, dval(0, 3, 2));
        step(); m_axi_ready = 1'b0; #1;
        chk("t4_c6_data", m_axi_data, dval(0, 3, 3));
        chk("t4_c6_busy", 64'(busy), 64'(1));
        step(); m_axi_ready = 1'b1; #1;
        chk("t4_c7_data", m_axi_data, dval(0, 3, 3));
        chk("t4_c7_s_ready", 64'(s_axi_ready), 64'(2'b01));
        src_on = 2'b00;
        step();
        chk("t4_gap_busy", 64'(busy), 64'(0));
        step();
        chk("t4_res_valid", 64'(res_valid), 64'(1));
        chk("t4_res_src", 64'(res_src), 64'(0));
        chk("t4_res_cks", 64'(res_checksum), 64'(16'hBEF5));

        // Orphan checksum
        chk("t5_pre_orphan", 64'(err_orphan), 64'(0));
        checksum_valid = 1'b1; checksum_data = 16'h1234;
        step();
        chk("t5_orphan", 64'(err_orphan), 64'(1));
        chk("t5_no_res", 64'(res_valid), 64'(0));
        chk("t5_cks_held", 64'(res_checksum), 64'(16'hBEF5));
        step();
        chk("t5_orphan_sticky", 64'(err_orphan), 64'(1));

        // Reset during beat 2 of a 4-beat packet
        src_on = 2'b11; plen = '{4, 4};
        drive(); #1;
        step();
        chk("t6_grant1", 64'(s_axi_ready), 64'(2'b10));
        chk("t6_b0_data", m_axi_data, dval(1, 3, 0));
        step();
        step();
        chk("t6_b2_data", m_axi_data, dval(1, 3, 2));
        aresetn = 1'b0;
        step();
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk("t6_rst_s_ready", 64'(s_axi_ready), 64'(0));
        chk("t6_rst_m_valid", 64'(m_axi_valid), 64'(0));
        chk("t6_rst_m_data", m_axi_data, 64'(0));
        chk("t6_rst_res_cks", 64'(res_checksum), 64'(0));
        chk("t6_rst_res_valid", 64'(res_valid), 64'(0));
        chk("t6_rst_orphan", 64'(err_orphan), 64'(0));
        aresetn = 1'b1; bc[1] = 0;
        drive(); #1;
        step();
        chk("t6_regrant_s_ready", 64'(s_axi_ready), 64'(2'b01));
        chk("t6_regrant_data", m_axi_data, dval(0, 4, 0));
        chk("t6_regrant_busy", 64'(busy), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
